clkspec_arbtst_nshared: RTL and testbench
=========================================

Name: clkspec_arbtst_nshared

Overview:
- N-channel shared arithmetic unit.
- Up to NCH requesters compete for one adder/subtractor through a round-robin arbiter. The granted channel's operands are captured and the result is computed.
- The result is presented on a single output port, tagged with the originating channel, and held until downstream accepts it.
- This is the parametrised successor of the fixed 4-channel add-only shared block. It adds channel-count/width generality, fair arbitration, subtract mode, carry/borrow out and output back-pressure.

Parameters:
- WIDTH, 4: operand and result width in bits.
- NCH, 4: number of requesting channels, 2..16.
- CHW, $clog2(NCH): width of the channel tag. Derived; not overridden.

Ports:
- clk, input, 1: clock, rising edge.
- reset, input, 1: asynchronous active-low reset.
- req, input, NCH: per-channel request, level.
- op, input, NCH: per-channel operation, 0 = add, 1 = subtract (a-b).
- a_in, input, NCH*WIDTH: channel i operand A at bits [i*WIDTH +: WIDTH].
- b_in, input, NCH*WIDTH: channel i operand B, same packing as a_in.
- ack, output, NCH: one-cycle pulse to the granted channel when its operands are captured.
- y, output, WIDTH: result.
- y_ch, output, CHW: channel index that produced y.
- y_carry, output, 1: carry out (add) or borrow (subtract).
- y_valid, output, 1: result valid.
- y_ready, input, 1: downstream accepts the result.

Behaviour:
- Reset (reset==0, asynchronous):
  - State goes to IDLE; round-robin pointer goes to 0.
  - ack, y, y_ch, y_carry and y_valid are all 0.
  - Any transaction in flight is discarded and no ack is issued for it.
- State IDLE:
  - req is sampled.
  - If any bit is set, grant index g is the first set bit at or after the pointer, searching upward modulo NCH. g is registered and the state goes to READ.
  - If no bit is set, the state stays in IDLE.
- State READ (exactly 1 cycle):
  - ack[g]=1; all other ack bits are 0.
  - On the clock edge: {y_carry,y} <= a+b (op[g]=0) or a-b (op[g]=1), computed at WIDTH+1 bits using a_in[g], b_in[g], op[g].
  - y_carry = bit WIDTH of the sum. For subtract this is the borrow: 1 when a<b unsigned.
  - On the same edge: y_ch <= g, pointer <= (g+1) mod NCH, state goes to WRITE.
- State WRITE:
  - y_valid=1; y, y_ch and y_carry are held stable.
  - If y_ready=1, the state goes to IDLE on that edge and y_valid falls the next cycle.
  - While y_ready=0, the state holds indefinitely.
  - y, y_ch and y_carry retain their last values after y_valid drops.
- Latency: request seen in IDLE at cycle t gives ack at t+1 and y_valid at t+2.
  - Minimum of 3 cycles per transaction with y_ready tied high.
  - Sustained throughput is one result per 3 cycles.
- Requester protocol:
  - Hold req, op, a_in and b_in stable until ack is seen, then deassert req on the following cycle.
  - If req is still high in a subsequent IDLE, that is a new request.
- Fairness: with all channels requesting continuously, grants cycle 0,1,...,NCH-1,0,... No channel waits more than NCH transactions.
- Boundary conditions:
  - A req that drops while the block is in READ or WRITE is never seen.
  - A req that rises during READ or WRITE is arbitrated at the next IDLE.
  - Pointer wrap: after a grant to NCH-1, the pointer is 0.
  - When NCH is not a power of two, the pointer never takes the unused codes.
  - Arithmetic wraps modulo 2^WIDTH. Overflow is reported only via y_carry; there is no saturation.
  - Illegal state encodings recover to IDLE.

Decomposition:
- Shared package:
  - State encodings IDLE, READ, WRITE as 2-bit localparams.
  - OP_ADD=0, OP_SUB=1.
- One sub-module, rr_arb_n (parameter NCH):
  - Inputs: req vector and pointer.
  - Outputs: combinational one-hot grant, binary grant index, any-request flag.
  - Pure combinational and unit-testable on its own.
- The top level holds the FSM, pointer, operand mux and result registers.

Test Plan:
- Reset mid-WRITE: set reset=0 while y_valid=1 -> y_valid, y, y_ch and ack are 0 immediately; the pointer is 0 after release. A subsequent req=4'b1000 gets ack[3] 1 cycle after sampling.
- Single add: req[2]=1, a=4'h9, b=4'h8, op=0, y_ready=1 -> ack=4'b0100 at t+1; at t+2 y=4'h1, y_carry=1, y_ch=2, y_valid=1 for exactly 1 cycle.
- Subtract with borrow: req[1], a=3, b=5, op=1 -> y=4'hE, y_carry=1, y_ch=1.
- Round-robin: req=4'b1111 held, y_ready=1 -> grant order 0,1,2,3,0 over 5 transactions, 3 cycles apart. Then req=4'b0101 with pointer at 1 -> grants 2,0,2.
- Back-pressure: y_ready=0 for 10 cycles after y_valid -> y, y_ch and y_carry stable, no ack during the stall; y_ready=1 -> IDLE next cycle and the pending req[3] is acked 1 cycle later.
- NCH=3, WIDTH=8: requests on all 3 channels -> pointer sequence 0,1,2,0. a=8'hFF+b=8'h01 -> y=8'h00, y_carry=1.

Source files
------------

// File: rtl/clkspec_arbtst_nshared_pkg.sv
// Shared constants for the N-channel shared add/subtract unit.
package clkspec_arbtst_nshared_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/clkspec_arbtst_nshared_if.sv
// Request/result bundle between requesters and the shared arithmetic unit.
interface clkspec_arbtst_nshared_if #(
  parameter int WIDTH = 4,
  parameter int NCH   = 4
);
  localparam int CHW = $clog2(NCH);

  logic [NCH-1:0]       req;
  logic [NCH-1:0]       op;
  logic [NCH*WIDTH-1:0] a_in;
  logic [NCH*WIDTH-1:0] b_in;
  logic [NCH-1:0]       ack;
  logic [WIDTH-1:0]     y;
  logic [CHW-1:0]       y_ch;
  logic                 y_carry;
  logic                 y_valid;
  logic                 y_ready;

  modport master (
    output req, op, a_in, b_in, y_ready,
    input  ack, y, y_ch, y_carry, y_valid
  );

  modport slave (
    input  req, op, a_in, b_in, y_ready,
    output ack, y, y_ch, y_carry, y_valid
  );
endinterface

// File: rtl/clkspec_arbtst_nshared_rr_arb_n.sv
// Combinational round-robin arbiter: first set request at or after ptr, modulo NCH.
module rr_arb_n #(
  parameter  int NCH = 4,
  localparam int CHW = $clog2(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [CHW-1:0] ptr,
  output logic [NCH-1:0] gnt,
  output logic [CHW-1:0] gnt_idx,
  output logic           any_req
);

  logic [CHW-1:0] rot_idx [NCH];

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_rot
      always_comb begin
        int s;
        s = int'(ptr) + gi;
        if (s >= NCH) s = s - NCH;
        rot_idx[gi] = CHW'(s);
      end
    end
  endgenerate

  // Scan from the farthest offset down so the nearest set request wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any_req = |req;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (req[rot_idx[k]]) gnt_idx = rot_idx[k];
    end
    if (any_req) gnt[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/clkspec_arbtst_nshared.sv
// N-channel shared adder/subtractor with round-robin arbitration and a held, tagged result.
module clkspec_arbtst_nshared
  import clkspec_arbtst_nshared_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int NCH   = 4
) (
  input logic                     clk,
  input logic                     reset,
  clkspec_arbtst_nshared_if.slave bus
);
  localparam int CHW = $clog2(NCH);

  logic [1:0]       state_reg;
  logic [CHW-1:0]   ptr_reg;
  logic [CHW-1:0]   g_reg;
  logic [NCH-1:0]   gnt_reg;
  logic [WIDTH-1:0] y_reg;
  logic [CHW-1:0]   y_ch_reg;
  logic             carry_reg;

  logic [NCH-1:0]   arb_gnt;
  logic [CHW-1:0]   arb_idx;
  logic             arb_any;
  logic [CHW-1:0]   ptr_next;

  logic [WIDTH-1:0] a_arr [NCH];
  logic [WIDTH-1:0] b_arr [NCH];
  logic [WIDTH-1:0] a_sel;
  logic [WIDTH-1:0] b_sel;
  logic             op_sel;
  logic [WIDTH:0]   sum;

  rr_arb_n #(.NCH(NCH)) u_arb (
    .req     (bus.req),
    .ptr     (ptr_reg),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .any_req (arb_any)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_unpack
      assign a_arr[gi] = bus.a_in[gi*WIDTH +: WIDTH];
      assign b_arr[gi] = bus.b_in[gi*WIDTH +: WIDTH];
    end
  endgenerate

  assign a_sel  = a_arr[g_reg];
  assign b_sel  = b_arr[g_reg];
  assign op_sel = bus.op[g_reg];

  // Extra top bit carries out on add and becomes the borrow on subtract.
  assign sum = (op_sel == OP_ADD) ? ({1'b0, a_sel} + {1'b0, b_sel})
                                  : ({1'b0, a_sel} - {1'b0, b_sel});

  assign ptr_next = (g_reg == CHW'(NCH - 1)) ? '0 : g_reg + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      g_reg     <= '0;
      gnt_reg   <= '0;
      y_reg     <= '0;
      y_ch_reg  <= '0;
      carry_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (arb_any) begin
            g_reg     <= arb_idx;
            gnt_reg   <= arb_gnt;
            state_reg <= READ;
          end
        end
        READ: begin
          {carry_reg, y_reg} <= sum;
          y_ch_reg           <= g_reg;
          ptr_reg            <= ptr_next;
          state_reg          <= WRITE;
        end
        WRITE: begin
          if (bus.y_ready) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.ack     = (state_reg == READ) ? gnt_reg : '0;
  assign bus.y_valid = (state_reg == WRITE);
  assign bus.y       = y_reg;
  assign bus.y_ch    = y_ch_reg;
  assign bus.y_carry = carry_reg;

endmodule

// File: tb/tb_clkspec_arbtst_nshared.sv
// Directed bench for the shared arithmetic unit: 4-ch/4-bit and 3-ch/8-bit instances.
module tb_clkspec_arbtst_nshared;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  clkspec_arbtst_nshared_if #(.WIDTH(4), .NCH(4)) bus4 ();
  clkspec_arbtst_nshared_if #(.WIDTH(8), .NCH(3)) bus3 ();

  clkspec_arbtst_nshared #(.WIDTH(4), .NCH(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4)
  );

  clkspec_arbtst_nshared #(.WIDTH(8), .NCH(3)) dut3 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set4(input int ch, input logic [3:0] a, input logic [3:0] b, input logic o);
    bus4.a_in[ch*4 +: 4] = a;
    bus4.b_in[ch*4 +: 4] = b;
    bus4.op[ch]          = o;
  endtask

  task automatic set3(input int ch, input logic [7:0] a, input logic [7:0] b, input logic o);
    bus3.a_in[ch*8 +: 8] = a;
    bus3.b_in[ch*8 +: 8] = b;
    bus3.op[ch]          = o;
  endtask

  int rr_ch  [8] = '{0, 1, 2, 3, 0, 2, 0, 2};
  int rr_y   [8] = '{3, 4, 5, 6, 3, 5, 3, 5};
  int n3_ch  [4] = '{0, 1, 2, 0};
  int n3_y   [4] = '{8'h00, 8'h15, 8'h50, 8'h00};
  int n3_c   [4] = '{1, 0, 0, 1};

  initial begin
    reset = 1'b0;
    bus4.req = '0; bus4.op = '0; bus4.a_in = '0; bus4.b_in = '0; bus4.y_ready = 1'b1;
    bus3.req = '0; bus3.op = '0; bus3.a_in = '0; bus3.b_in = '0; bus3.y_ready = 1'b1;
    #2;
    chk("rst_ack",     32'(bus4.ack), 0);
    chk("rst_y",       32'(bus4.y), 0);
    chk("rst_y_ch",    32'(bus4.y_ch), 0);
    chk("rst_y_carry", 32'(bus4.y_carry), 0);
    chk("rst_y_valid", 32'(bus4.y_valid), 0);
    chk("rst3_y_valid", 32'(bus3.y_valid), 0);
    chk("rst3_ack",     32'(bus3.ack), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    tick();

    // Single add on channel 2: 9+8 = 0x11
    set4(2, 4'h9, 4'h8, 1'b0);
    bus4.req = 4'b0100;
    tick();
    chk("add_ack", 32'(bus4.ack), 32'b0100);
    chk("add_valid_early", 32'(bus4.y_valid), 0);
    bus4.req = '0;
    tick();
    chk("add_valid", 32'(bus4.y_valid), 1);
    chk("add_y",     32'(bus4.y), 32'h1);
    chk("add_carry", 32'(bus4.y_carry), 1);
    chk("add_ch",    32'(bus4.y_ch), 2);
    chk("add_ack_off", 32'(bus4.ack), 0);
    tick();
    chk("add_valid_fall", 32'(bus4.y_valid), 0);
    chk("add_y_hold",     32'(bus4.y), 32'h1);

    // Subtract with borrow on channel 1: 3-5 = 0xE, pointer at 3 wraps to 1
    set4(1, 4'h3, 4'h5, 1'b1);
    bus4.req = 4'b0010;
    tick();
    chk("sub_ack", 32'(bus4.ack), 32'b0010);
    bus4.req = '0;
    tick();
    chk("sub_y",     32'(bus4.y), 32'hE);
    chk("sub_carry", 32'(bus4.y_carry), 1);
    chk("sub_ch",    32'(bus4.y_ch), 1);
    tick();

    // Reset in the middle of WRITE
    set4(0, 4'h5, 4'h6, 1'b0);
    bus4.op[1] = 1'b0;
    bus4.req = 4'b0001;
    tick();
    chk("mw_ack", 32'(bus4.ack), 32'b0001);
    bus4.req = '0;
    tick();
    chk("mw_valid_pre", 32'(bus4.y_valid), 1);
    chk("mw_y_pre",     32'(bus4.y), 32'hB);
    reset = 1'b0;
    #1;
    chk("mw_valid", 32'(bus4.y_valid), 0);
    chk("mw_y",     32'(bus4.y), 0);
    chk("mw_ch",    32'(bus4.y_ch), 0);
    chk("mw_ack0",  32'(bus4.ack), 0);
    chk("mw_carry", 32'(bus4.y_carry), 0);
    #2;
    reset = 1'b1;
    set4(3, 4'h7, 4'h2, 1'b1);
    bus4.req = 4'b1000;
    tick();
    chk("mw_ack3", 32'(bus4.ack), 32'b1000);
    bus4.req = '0;
    tick();
    chk("mw_y3",     32'(bus4.y), 32'h5);
    chk("mw_carry3", 32'(bus4.y_carry), 0);
    chk("mw_ch3",    32'(bus4.y_ch), 3);
    tick();

    // Round-robin: all channels then 0101 with pointer at 1
    set4(0, 4'h1, 4'h2, 1'b0);
    set4(1, 4'h2, 4'h2, 1'b0);
    set4(2, 4'h3, 4'h2, 1'b0);
    set4(3, 4'h4, 4'h2, 1'b0);
    for (int k = 0; k < 8; k++) begin
      bus4.req = (k < 5) ? 4'b1111 : 4'b0101;
      tick();
      chk($sformatf("rr%0d_ack", k), 32'(bus4.ack), 32'(1 << rr_ch[k]));
      tick();
      chk($sformatf("rr%0d_ch", k), 32'(bus4.y_ch), 32'(rr_ch[k]));
      chk($sformatf("rr%0d_y", k),  32'(bus4.y), 32'(rr_y[k]));
      tick();
      chk($sformatf("rr%0d_idle", k), 32'(bus4.y_valid), 0);
    end
    bus4.req = '0;

    // Back-pressure: pointer at 3, ch1 granted; ch3 waits through a 10-cycle stall
    bus4.y_ready = 1'b0;
    set4(1, 4'hC, 4'h7, 1'b0);
    bus4.req = 4'b0010;
    tick();
    chk("bp_ack1", 32'(bus4.ack), 32'b0010);
    set4(3, 4'h2, 4'h9, 1'b1);
    bus4.req = 4'b1000;
    tick();
    chk("bp_valid", 32'(bus4.y_valid), 1);
    for (int k = 0; k < 10; k++) begin
      if (k == 3) bus4.req[0] = 1'b1;
      if (k == 6) bus4.req[0] = 1'b0;
      tick();
      chk($sformatf("bp%0d_valid", k), 32'(bus4.y_valid), 1);
      chk($sformatf("bp%0d_y", k),     32'(bus4.y), 32'h3);
      chk($sformatf("bp%0d_ch", k),    32'(bus4.y_ch), 1);
      chk($sformatf("bp%0d_carry", k), 32'(bus4.y_carry), 1);
      chk($sformatf("bp%0d_ack", k),   32'(bus4.ack), 0);
    end
    bus4.y_ready = 1'b1;
    tick();
    chk("bp_idle_valid", 32'(bus4.y_valid), 0);
    chk("bp_idle_ack",   32'(bus4.ack), 0);
    tick();
    chk("bp_ack3", 32'(bus4.ack), 32'b1000);
    bus4.req = '0;
    tick();
    chk("bp_y3",     32'(bus4.y), 32'h9);
    chk("bp_carry3", 32'(bus4.y_carry), 1);
    chk("bp_ch3",    32'(bus4.y_ch), 3);
    tick();
    chk("bp_end_valid", 32'(bus4.y_valid), 0);

    // Three-channel, 8-bit instance
    set3(0, 8'hFF, 8'h01, 1'b0);
    set3(1, 8'h10, 8'h05, 1'b0);
    set3(2, 8'h20, 8'h30, 1'b0);
    bus3.req = 3'b111;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("n3_%0d_ack", k), 32'(bus3.ack), 32'(1 << n3_ch[k]));
      tick();
      chk($sformatf("n3_%0d_ch", k),    32'(bus3.y_ch), 32'(n3_ch[k]));
      chk($sformatf("n3_%0d_y", k),     32'(bus3.y), 32'(n3_y[k]));
      chk($sformatf("n3_%0d_carry", k), 32'(bus3.y_carry), 32'(n3_c[k]));
      tick();
    end
    bus3.req = '0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
